// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with prefetch FIFO and branch redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   START_PC = {RESET_PC[31:2], 2'b00};

  // IDLE: nothing outstanding; BUSY: request outstanding; DRAIN: outstanding, result discarded
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          done;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic          issue;
  logic [31:0]   target;
  logic [31:0]   fpc_next;
  logic [CW-1:0] count_next;
  logic          unused_redirect_bits;

  // The low target bits are dropped: fetch addresses are always word aligned
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign instr_valid = (count != '0);
  assign instr       = instr_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Per-edge decisions: completion, push/pop, next occupancy and whether a new request may start
  always_comb begin
    done       = imem_req & imem_ack;
    push       = done & (state == BUSY) & ~redirect;
    pop        = instr_valid & instr_ready;
    target     = {redirect_pc[31:2], 2'b00};
    count_next = '0;
    if (!redirect) begin
      count_next = count + CW'(push) - CW'(pop);
    end
    fpc_next = fpc;
    if (redirect) begin
      fpc_next = target;
    end else if (push) begin
      fpc_next = fpc + 32'd4;
    end
    // After a completion (or when idle) nothing is outstanding, so only buffer space matters
    slot_free = (state == IDLE) | done;
    issue     = slot_free & (count_next < FULL_CNT);
  end

  // Request FSM with registered imem_req/imem_addr and the fetch PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= START_PC;
      fpc       <= START_PC;
      count     <= '0;
    end else begin
      fpc   <= fpc_next;
      count <= count_next;
      if (slot_free) begin
        if (issue) begin
          state     <= BUSY;
          imem_req  <= 1'b1;
          imem_addr <= fpc_next;
        end else begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      end else if (redirect) begin
        // Keep the in-flight request alive but mark its data for discard
        state <= DRAIN;
      end
    end
  end

  // Prefetch FIFO storage and pointers; a redirect empties it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= imem_addr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset, word aligned.
REQ-002 Parameter DEPTH, default 2, is the prefetch buffer entry count; legal range is 2 to 4.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port imem_req, output, 1 bit: instruction-memory read request, registered.
REQ-006 Port imem_addr, output, 32 bits: read address, registered, bits [1:0] always 0.
REQ-007 Port imem_ack, input, 1 bit: memory completion strobe; imem_rdata is valid in the same cycle.
REQ-008 Port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 Port instr_valid, output, 1 bit: instr and instr_pc hold a valid fetched instruction.
REQ-010 Port instr, output, 32 bits: instruction word to the controller/datapath (Instr[31:0]).
REQ-011 Port instr_pc, output, 32 bits: address the presented instruction was fetched from.
REQ-012 Port instr_ready, input, 1 bit: consumer accepts the presented instruction this cycle.
REQ-013 Port redirect, input, 1 bit: branch taken (driven from PCSrc); flush and refetch.
REQ-014 Port redirect_pc, input, 32 bits: branch target; bits [1:0] ignored and treated as 00.

Function
REQ-015 Fetch PC fpc SHALL advance by 4 per accepted memory completion, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-016 At most one memory request SHALL be outstanding; a request is outstanding from the edge asserting imem_req until the edge sampling imem_req=1 and imem_ack=1.
REQ-017 While a request is outstanding, imem_req SHALL stay 1 and imem_addr SHALL stay constant.
REQ-018 imem_ack sampled while imem_req=0 SHALL be ignored.
REQ-019 A new request SHALL be issued only when buffer occupancy plus outstanding requests is less than DEPTH after the current edge's push/pop.
REQ-020 On a completion edge with space remaining, imem_req SHALL stay 1 and imem_addr SHALL become fpc+4 (back-to-back, one word per cycle with zero-wait memory).
REQ-021 Buffer is a FIFO of {instr, pc} entries; instr_valid = (count != 0); instr/instr_pc show the oldest entry.
REQ-022 Push on non-discarded completion; pop on instr_valid && instr_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 instr, instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-024 Redirect edge: FIFO count SHALL become 0; fpc SHALL become {redirect_pc[31:2],2'b00}; a handshake completing in that cycle counts as consumed.
REQ-025 Redirect with no outstanding request: imem_req=1 with imem_addr=redirect target at the next edge.
REQ-026 Redirect with outstanding request: request SHALL NOT be cancelled; its completion data SHALL be discarded; request to the target issues on the completion edge.
REQ-027 Redirect coinciding with a completion: returned data SHALL be discarded; target request issues at the same edge.
REQ-028 Redirect while a discard is pending SHALL replace the target and keep exactly one pending discard.
REQ-029 Discard-pending state: IDLE, BUSY (request outstanding), DRAIN (outstanding, result discarded); DRAIN -> BUSY on ack.

Reset
REQ-030 reset=0 SHALL immediately force imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, FIFO count=0, state IDLE, discard clear, fpc=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon it; acks arriving during or after reset for it are ignored.
REQ-032 First edge after reset release SHALL assert imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-033 Zero-wait memory (ack every cycle), instr_ready=1 -> instr_pc sequence 0,4,8,C... one per cycle after 2-cycle startup.
REQ-034 instr_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_req=0, no lost/duplicated PCs on release.
REQ-035 3-cycle ack latency, redirect to 32'h0000_0103 while outstanding -> old data dropped, next imem_addr=32'h0000_0100, first instr_pc=32'h100.
REQ-036 Redirect same cycle as ack at addr 8, target 32'h40 -> word from 8 never presented, next instr_pc=32'h40.
REQ-037 redirect_pc=32'hFFFF_FFF8, zero-wait -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 reset=0 asserted between req and ack, late ack applied -> instr_valid=0, fetch restarts at RESET_PC.
